hilo_muldiv_ctrl: RTL and testbench

//   Sequences the shared multiply/divide resource and owns the HI/LO register pair.

---
 rtl/hilo_muldiv_ctrl.sv | 153 +++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register pair with the shared multiply/divide sequencer for the EX stage.
// Multiplies take MUL_CYCLES extra cycles; divides run a 32-step radix-2 shift-subtract loop.
module hilo_muldiv_ctrl #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall,
    output logic        busy
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);
    localparam logic [4:0] DIV_LAST = 5'd31;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t      state;
    logic [4:0]  count;
    logic [63:0] product;
    logic [31:0] dvd;        // dividend shifts out the top while quotient bits shift in
    logic [31:0] divisor;
    logic [32:0] rem;
    logic        div_signed;
    logic        sign_a;
    logic        sign_b;
    logic        div_zero;

    logic        is_mul;
    logic        is_div;
    logic        accept;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] rem_sh;
    logic [32:0] rem_sub;
    logic        q_bit;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign accept = (state == IDLE) && start && !flush;
    assign stall  = (accept && (is_mul || is_div)) || (state != IDLE);

    // Sign- or zero-extending to 64 bits lets one unsigned multiplier serve both MULT and MULTU.
    assign mul_a = (op == OP_MULT) ? {{32{a[31]}}, a} : {32'b0, a};
    assign mul_b = (op == OP_MULT) ? {{32{b[31]}}, b} : {32'b0, b};
    assign abs_a = ((op == OP_DIV) && a[31]) ? -a : a;
    assign abs_b = ((op == OP_DIV) && b[31]) ? -b : b;

    assign rem_sh  = (rem << 1) | {32'b0, dvd[31]};
    assign rem_sub = rem_sh - {1'b0, divisor};
    assign q_bit   = (rem_sh >= {1'b0, divisor});

    assign quot_fix = (div_signed && (sign_a ^ sign_b)) ? -dvd : dvd;
    assign rem_fix  = (div_signed && sign_a) ? -rem[31:0] : rem[31:0];

    // NOTE: all state here is sequential, so it is written only with non-blocking (<=)
    // assignments; blocking ones would make later reads in this block see half-updated values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            count      <= '0;
            hi         <= '0;
            lo         <= '0;
            product    <= '0;
            dvd        <= '0;
            divisor    <= '0;
            rem        <= '0;
            div_signed <= 1'b0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            div_zero   <= 1'b0;
        end else if (flush) begin
            // Abort whatever is in flight; HI/LO keep their architectural values.
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end else if (is_mul) begin
                            product <= mul_a * mul_b;
                            count   <= '0;
                            state   <= MUL;
                            busy    <= 1'b1;
                        end else if (is_div) begin
                            dvd        <= abs_a;
                            divisor    <= abs_b;
                            rem        <= '0;
                            sign_a     <= a[31];
                            sign_b     <= b[31];
                            div_signed <= (op == OP_DIV);
                            div_zero   <= (b == 32'b0);
                            count      <= '0;
                            state      <= (b == 32'b0) ? FIX : DIV;
                            busy       <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    count <= count + 5'd1;
                    if (count == MUL_LAST) begin
                        {hi, lo} <= product;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end
                end
                DIV: begin
                    rem   <= q_bit ? rem_sub : rem_sh;
                    dvd   <= {dvd[30:0], q_bit};
                    count <= count + 5'd1;
                    if (count == DIV_LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (!div_zero) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: timing of stall/busy, HI/LO results, flush and reset.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_hilo_muldiv_ctrl;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hilo_muldiv_ctrl #(.MUL_CYCLES(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .hi    (hi),
        .lo    (lo),
        .stall (stall),
        .busy  (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issues one op in cycle 0, then counts cycles with stall high (bounded), ending at the
    // falling edge of the first cycle with stall low.
    task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input int exp_cycles, input string tag);
        int n;
        next_cycle();
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        n     = 0;
        @(negedge clk);
        chk({tag, " busy c0"}, 32'(busy), 32'd0);
        while (stall === 1'b1 && n < 100) begin
            n++;
            next_cycle();
            start = 1'b0;
            op    = 3'b000;
            @(negedge clk);
            if (n == 1) chk({tag, " busy c1"}, 32'(busy), 32'd1);
        end
        chk({tag, " stall cycles"}, 32'(n), 32'(exp_cycles));
        chk({tag, " busy end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;

        // Reset
        #1 rst = 1'b1;
        #2;
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Multiplies: stall cycles 0..2, result in cycle 3
        run_op(OP_MULT, 32'hFFFFFFFE, 32'h3, 3, "mult -2*3");
        chk("mult -2*3 hi", hi, 32'hFFFFFFFF);
        chk("mult -2*3 lo", lo, 32'hFFFFFFFA);
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, "multu max");
        chk("multu max hi", hi, 32'hFFFFFFFE);
        chk("multu max lo", lo, 32'h00000001);

        // Divides: stall cycles 0..33, result in cycle 34
        run_op(OP_DIV, 32'hFFFFFFF9, 32'h2, 34, "div -7/2");
        chk("div -7/2 lo", lo, 32'hFFFFFFFD);
        chk("div -7/2 hi", hi, 32'hFFFFFFFF);
        run_op(OP_DIVU, 32'd100, 32'd7, 34, "divu 100/7");
        chk("divu 100/7 lo", lo, 32'd14);
        chk("divu 100/7 hi", hi, 32'd2);
        run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, 34, "div 7/-2");
        chk("div 7/-2 lo", lo, 32'hFFFFFFFD);
        chk("div 7/-2 hi", hi, 32'h00000001);
        run_op(OP_DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, 34, "div -7/-2");
        chk("div -7/-2 lo", lo, 32'h00000003);
        chk("div -7/-2 hi", hi, 32'hFFFFFFFF);
        run_op(OP_DIVU, 32'hFFFFFFFF, 32'hC0000000, 34, "divu big");
        chk("divu big lo", lo, 32'h00000001);
        chk("divu big hi", hi, 32'h3FFFFFFF);
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 34, "div ovf");
        chk("div ovf lo", lo, 32'h80000000);
        chk("div ovf hi", hi, 32'h00000000);

        // Divide by zero: two stall cycles, HI/LO untouched
        run_op(OP_DIV, 32'd5, 32'd0, 2, "div by 0");
        chk("div by 0 lo", lo, 32'h80000000);
        chk("div by 0 hi", hi, 32'h00000000);

        // MTHI then MTLO back to back, never stalling
        next_cycle();
        start = 1'b1;
        op    = OP_MTHI;
        a     = 32'h1234;
        @(negedge clk);
        chk("mthi stall", 32'(stall), 32'd0);
        next_cycle();
        op = OP_MTLO;
        a  = 32'h5678;
        @(negedge clk);
        chk("mtlo stall", 32'(stall), 32'd0);
        chk("mthi hi", hi, 32'h1234);
        next_cycle();
        start = 1'b0;
        op    = 3'b000;
        @(negedge clk);
        chk("mtlo lo", lo, 32'h5678);
        chk("mthi/mtlo hi kept", hi, 32'h1234);
        chk("mthi/mtlo busy", 32'(busy), 32'd0);

        // Start held high during MUL with a different op is ignored
        next_cycle();
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd3;
        b     = 32'd5;
        next_cycle();
        op = OP_MTHI;
        a  = 32'hDEAD;
        next_cycle();
        @(negedge clk);
        chk("held start stall c2", 32'(stall), 32'd1);
        next_cycle();
        start = 1'b0;
        op    = 3'b000;
        @(negedge clk);
        chk("held start hi", hi, 32'h0);
        chk("held start lo", lo, 32'd15);
        chk("held start stall c3", 32'(stall), 32'd0);

        // Restore known HI/LO for the flush tests
        run_op(OP_DIVU, 32'd100, 32'd7, 34, "divu setup");

        // Flush in DIV cycle 10
        next_cycle();
        start = 1'b1;
        op    = OP_DIV;
        a     = 32'd100;
        b     = 32'd3;
        repeat (10) begin
            next_cycle();
            start = 1'b0;
            op    = 3'b000;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("flush div c10 stall", 32'(stall), 32'd1);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        chk("flush div stall after", 32'(stall), 32'd0);
        chk("flush div busy after", 32'(busy), 32'd0);
        chk("flush div hi", hi, 32'd2);
        chk("flush div lo", lo, 32'd14);

        // Flush in the FIX cycle (cycle 33) must not write HI/LO
        next_cycle();
        start = 1'b1;
        op    = OP_DIVU;
        a     = 32'd100;
        b     = 32'd3;
        repeat (33) begin
            next_cycle();
            start = 1'b0;
            op    = 3'b000;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("flush fix busy", 32'(busy), 32'd1);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        chk("flush fix busy after", 32'(busy), 32'd0);
        chk("flush fix hi", hi, 32'd2);
        chk("flush fix lo", lo, 32'd14);

        // Flush together with start in IDLE drops the start
        next_cycle();
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd3;
        b     = 32'd5;
        flush = 1'b1;
        @(negedge clk);
        chk("flush start stall", 32'(stall), 32'd0);
        next_cycle();
        start = 1'b0;
        op    = 3'b000;
        flush = 1'b0;
        @(negedge clk);
        chk("flush start busy", 32'(busy), 32'd0);
        chk("flush start lo", lo, 32'd14);

        // Reset pulse in the middle of a MUL clears HI/LO and stall immediately
        next_cycle();
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd3;
        b     = 32'd5;
        next_cycle();
        start = 1'b0;
        op    = 3'b000;
        #1;
        chk("mid-mul stall before rst", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst mid-mul hi", hi, 32'h0);
        chk("rst mid-mul lo", lo, 32'h0);
        chk("rst mid-mul stall", 32'(stall), 32'd0);
        chk("rst mid-mul busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("after rst stall", 32'(stall), 32'd0);
        chk("after rst lo", lo, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
